// File: rtl/pe_double2int.sv
// pe_double2int: 4-stage pipelined IEEE-754 double -> signed int64 converter
// with a per-sample bypass mode. Conversion truncates toward zero and
// saturates NaN, infinities and out-of-range operands, raising out_ovf.
module pe_double2int #(
   parameter int latency       = 4,
   parameter int dwidth_double = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [dwidth_double-1:0] inp1,
   input  logic                     t_valid_inp1,
   input  logic [1:0]               op,
   output logic [dwidth_double-1:0] out1,
   output logic                     t_valid_out1,
   output logic                     out_ovf
);

   typedef enum logic [1:0] {
      SEL_SHIFT = 2'd0,
      SEL_ZERO  = 2'd1,
      SEL_MAX   = 2'd2,
      SEL_MIN   = 2'd3
   } sel_e;

   localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

   // Only the 4-deep pipeline over 64-bit words is implemented.
   if (latency != 4 || dwidth_double != 64) begin : g_param_check
      $error("pe_double2int supports only latency=4 and dwidth_double=64");
   end

   // op[1] is reserved and carries no meaning
   logic op_unused_s;
   assign op_unused_s = op[1];

   // ---------------- stage 1: unpack and classify ----------------
   logic [63:0] s1_word_r;
   logic        s1_conv_r, s1_vld_r, s1_sign_r;
   logic [10:0] s1_exp_r;
   logic [51:0] s1_frac_r;
   logic        s1_zero_r, s1_inf_r, s1_nan_r;

   // Capture the operand, its mode and qualifier, and its IEEE class
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_word_r <= 64'd0;
         s1_conv_r <= 1'b0;
         s1_vld_r  <= 1'b0;
         s1_sign_r <= 1'b0;
         s1_exp_r  <= 11'd0;
         s1_frac_r <= 52'd0;
         s1_zero_r <= 1'b0;
         s1_inf_r  <= 1'b0;
         s1_nan_r  <= 1'b0;
      end else begin
         s1_word_r <= inp1;
         s1_conv_r <= op[0];
         s1_vld_r  <= t_valid_inp1;
         s1_sign_r <= inp1[63];
         s1_exp_r  <= inp1[62:52];
         s1_frac_r <= inp1[51:0];
         s1_zero_r <= (inp1[62:52] == 11'h000);
         s1_inf_r  <= (inp1[62:52] == 11'h7FF) && (inp1[51:0] == 52'd0);
         s1_nan_r  <= (inp1[62:52] == 11'h7FF) && (inp1[51:0] != 52'd0);
      end
   end

   // ---------------- stage 2: exponent, shift plan, saturation ----------------
   logic signed [11:0] e_s;
   sel_e               sel_s;
   logic               ovf_s;
   logic               shl_s;
   logic [5:0]         shamt_s;

   assign e_s = $signed({1'b0, s1_exp_r}) - 12'sd1023;

   // Decide between a shifted result and one of the fixed saturation values
   always_comb begin
      sel_s   = SEL_SHIFT;
      ovf_s   = 1'b0;
      shl_s   = 1'b0;
      shamt_s = 6'd0;
      if (s1_nan_r) begin
         sel_s = SEL_MIN;
         ovf_s = 1'b1;
      end else if (s1_inf_r) begin
         sel_s = s1_sign_r ? SEL_MIN : SEL_MAX;
         ovf_s = 1'b1;
      end else if (s1_zero_r || (e_s < 12'sd0)) begin
         sel_s = SEL_ZERO;
      end else if (e_s >= 12'sd63) begin
         if (!s1_sign_r) begin
            sel_s = SEL_MAX;
            ovf_s = 1'b1;
         end else if (e_s > 12'sd63) begin
            sel_s = SEL_MIN;
            ovf_s = 1'b1;
         end else begin
            // e = 63 negative: only exactly -2^63 is representable
            sel_s = SEL_MIN;
            ovf_s = (s1_frac_r != 52'd0);
         end
      end else if (e_s >= 12'sd52) begin
         // e in 52..62: low six bits minus 52 give 0..10
         shl_s   = 1'b1;
         shamt_s = e_s[5:0] - 6'd52;
      end else begin
         // e in 0..51: right shift by 52..1, fraction bits drop out
         shl_s   = 1'b0;
         shamt_s = 6'd52 - e_s[5:0];
      end
   end

   logic [63:0] s2_word_r;
   logic        s2_conv_r, s2_vld_r, s2_sign_r, s2_ovf_r, s2_shl_r;
   sel_e        s2_sel_r;
   logic [5:0]  s2_shamt_r;
   logic [52:0] s2_sig_r;

   // Register the shift plan together with the significand (hidden 1 restored)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_word_r  <= 64'd0;
         s2_conv_r  <= 1'b0;
         s2_vld_r   <= 1'b0;
         s2_sign_r  <= 1'b0;
         s2_ovf_r   <= 1'b0;
         s2_shl_r   <= 1'b0;
         s2_sel_r   <= SEL_SHIFT;
         s2_shamt_r <= 6'd0;
         s2_sig_r   <= 53'd0;
      end else begin
         s2_word_r  <= s1_word_r;
         s2_conv_r  <= s1_conv_r;
         s2_vld_r   <= s1_vld_r;
         s2_sign_r  <= s1_sign_r;
         s2_ovf_r   <= ovf_s;
         s2_shl_r   <= shl_s;
         s2_sel_r   <= sel_s;
         s2_shamt_r <= shamt_s;
         s2_sig_r   <= {1'b1, s1_frac_r};
      end
   end

   // ---------------- stage 3: barrel shift to magnitude ----------------
   logic [63:0] sig_ext_s;
   logic [63:0] mag_s;

   assign sig_ext_s = {11'd0, s2_sig_r};
   assign mag_s     = s2_shl_r ? (sig_ext_s << s2_shamt_r) : (sig_ext_s >> s2_shamt_r);

   logic [63:0] s3_word_r, s3_mag_r;
   logic        s3_conv_r, s3_vld_r, s3_sign_r, s3_ovf_r;
   sel_e        s3_sel_r;

   // Register the truncated magnitude
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s3_word_r <= 64'd0;
         s3_mag_r  <= 64'd0;
         s3_conv_r <= 1'b0;
         s3_vld_r  <= 1'b0;
         s3_sign_r <= 1'b0;
         s3_ovf_r  <= 1'b0;
         s3_sel_r  <= SEL_SHIFT;
      end else begin
         s3_word_r <= s2_word_r;
         s3_mag_r  <= mag_s;
         s3_conv_r <= s2_conv_r;
         s3_vld_r  <= s2_vld_r;
         s3_sign_r <= s2_sign_r;
         s3_ovf_r  <= s2_ovf_r;
         s3_sel_r  <= s2_sel_r;
      end
   end

   // ---------------- stage 4: sign, saturation, output ----------------
   logic [63:0] res_s;

   // Apply sign to the magnitude or substitute the saturation value
   always_comb begin
      res_s = 64'd0;
      case (s3_sel_r)
         SEL_SHIFT: res_s = s3_sign_r ? (~s3_mag_r + 64'd1) : s3_mag_r;
         SEL_ZERO:  res_s = 64'd0;
         SEL_MAX:   res_s = INT_MAX;
         SEL_MIN:   res_s = INT_MIN;
         default:   res_s = 64'd0;
      endcase
   end

   // Register the final result, choosing converted or bypassed data per sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out1         <= 64'd0;
         out_ovf      <= 1'b0;
         t_valid_out1 <= 1'b0;
      end else begin
         out1         <= s3_conv_r ? res_s : s3_word_r;
         out_ovf      <= s3_conv_r & s3_ovf_r;
         t_valid_out1 <= s3_vld_r;
      end
   end

endmodule

// File: tb/tb_pe_double2int.sv
// Self-checking bench for pe_double2int: directed vector table, alternating
// stream, mid-stream reset and randomized samples against a real-arithmetic model.
module tb_pe_double2int;

   logic        clk;
   logic        rst;
   logic [63:0] inp1;
   logic        t_valid_inp1;
   logic [1:0]  op;
   logic [63:0] out1;
   logic        t_valid_out1;
   logic        out_ovf;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] MAXI = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINI = 64'h8000_0000_0000_0000;

   pe_double2int #(.latency(4), .dwidth_double(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .inp1         (inp1),
      .t_valid_inp1 (t_valid_inp1),
      .op           (op),
      .out1         (out1),
      .t_valid_out1 (t_valid_out1),
      .out_ovf      (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        ovf;
      logic [63:0] out;
      logic [31:0] tag;
   } exp_t;

   typedef struct {
      logic [63:0] w;
      logic [1:0]  o;
      logic [63:0] eo;
      logic        eovf;
   } vec_t;

   exp_t q[$];
   vec_t tbl[19];
   int   tag_n = 0;

   task automatic chk(input string nm, input int tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s sample=%0d got=%h expected=%h", nm, tag, got, want);
      end
   endtask

   // Reference: convert via real arithmetic, truncating toward zero.
   function automatic logic [64:0] model(input logic [63:0] w, input logic [1:0] o);
      real    r;
      longint li;
      if (!o[0]) return {1'b0, w};
      if (w[62:52] == 11'h7FF) begin
         if (w[51:0] != 52'd0) return {1'b1, MINI};
         return w[63] ? {1'b1, MINI} : {1'b1, MAXI};
      end
      r = $bitstoreal(w);
      if (r >= 9223372036854775808.0) return {1'b1, MAXI};
      if (r < -9223372036854775808.0) return {1'b1, MINI};
      li = longint'(r);
      if (r >= 0.0 && real'(li) > r) li = li - 64'sd1;
      if (r < 0.0 && real'(li) < r) li = li + 64'sd1;
      return {1'b0, li};
   endfunction

   task automatic push_zeros();
      exp_t z;
      z = '0;
      z.tag = 32'hFFFF_FFFF;
      q.delete();
      repeat (3) q.push_back(z);
   endtask

   // Present one sample for one clock; then check the output leaving the pipe.
   task automatic step(input logic [63:0] w, input logic [1:0] o, input logic v,
                       input logic [63:0] eo, input logic eovf);
      exp_t e;
      inp1 = w;
      op = o;
      t_valid_inp1 = v;
      @(posedge clk);
      e.v = v; e.ovf = eovf; e.out = eo; e.tag = 32'(tag_n);
      tag_n++;
      q.push_back(e);
      #1;
      if (q.size() >= 4) begin
         e = q.pop_front();
         chk("t_valid_out1", int'(e.tag), {63'd0, t_valid_out1}, {63'd0, e.v});
         chk("out1", int'(e.tag), out1, e.out);
         chk("out_ovf", int'(e.tag), {63'd0, out_ovf}, {63'd0, e.ovf});
      end
   endtask

   task automatic stepm(input logic [63:0] w, input logic [1:0] o, input logic v);
      logic [64:0] m;
      m = model(w, o);
      step(w, o, v, m[63:0], m[64]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(64'd0, 2'b00, 1'b0, 64'd0, 1'b0);
   endtask

   initial begin
      logic [63:0] w;
      logic [1:0]  o;
      logic        v;
      int          k;

      tbl[0]  = '{64'h400D_9999_9999_999A, 2'b01, 64'd3,                  1'b0};
      tbl[1]  = '{64'hC00D_9999_9999_999A, 2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
      tbl[2]  = '{64'h43E0_0000_0000_0000, 2'b01, MAXI,                   1'b1};
      tbl[3]  = '{64'hC3E0_0000_0000_0000, 2'b01, MINI,                   1'b0};
      tbl[4]  = '{64'h7FF0_0000_0000_0000, 2'b01, MAXI,                   1'b1};
      tbl[5]  = '{64'h7FF8_0000_0000_0000, 2'b01, MINI,                   1'b1};
      tbl[6]  = '{64'h3FE0_0000_0000_0000, 2'b01, 64'd0,                  1'b0};
      tbl[7]  = '{64'h0000_0000_0000_0001, 2'b01, 64'd0,                  1'b0};
      tbl[8]  = '{64'h0123_4567_89AB_CDEF, 2'b00, 64'h0123_4567_89AB_CDEF, 1'b0};
      tbl[9]  = '{64'hFFF0_0000_0000_0000, 2'b01, MINI,                   1'b1};
      tbl[10] = '{64'h8000_0000_0000_0000, 2'b01, 64'd0,                  1'b0};
      tbl[11] = '{64'h3FF0_0000_0000_0000, 2'b01, 64'd1,                  1'b0};
      tbl[12] = '{64'h43D0_0000_0000_0000, 2'b01, 64'h4000_0000_0000_0000, 1'b0};
      tbl[13] = '{64'hC3E0_0000_0000_0001, 2'b01, MINI,                   1'b1};
      tbl[14] = '{64'h4330_0000_0000_0001, 2'b01, 64'h0010_0000_0000_0001, 1'b0};
      tbl[15] = '{64'hFFF0_0000_0000_0001, 2'b01, MINI,                   1'b1};
      tbl[16] = '{64'h7FF8_0000_0000_0000, 2'b10, 64'h7FF8_0000_0000_0000, 1'b0};
      tbl[17] = '{64'h400D_9999_9999_999A, 2'b11, 64'd3,                  1'b0};
      tbl[18] = '{64'hC3DF_FFFF_FFFF_FFFF, 2'b01, 64'h8000_0000_0000_0400, 1'b0};

      // power-on reset state
      rst = 1'b0;
      inp1 = 64'h0123_4567_89AB_CDEF;
      op = 2'b01;
      t_valid_inp1 = 1'b1;
      #12;
      chk("reset out1", -1, out1, 64'd0);
      chk("reset out_ovf", -1, {63'd0, out_ovf}, 64'd0);
      chk("reset t_valid_out1", -1, {63'd0, t_valid_out1}, 64'd0);
      #10;
      rst = 1'b1;
      push_zeros();

      // directed vectors, back to back
      for (int i = 0; i < 19; i++) step(tbl[i].w, tbl[i].o, 1'b1, tbl[i].eo, tbl[i].eovf);
      idle(4);

      // alternating convert/bypass stream of 8 samples
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) stepm($realtobits(real'(i / 2 + 1)), 2'b01, 1'b1);
         else stepm({$urandom, $urandom}, 2'b00, 1'b1);
      end
      idle(4);

      // reset after 2 of 4 streamed samples are accepted
      for (int i = 0; i < 3; i++) stepm(64'hAAAA_5555_AAAA_5555, 2'b00, 1'b1);
      stepm($realtobits(5.0), 2'b01, 1'b1);
      stepm($realtobits(6.0), 2'b01, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      chk("async reset out1", -2, out1, 64'd0);
      chk("async reset out_ovf", -2, {63'd0, out_ovf}, 64'd0);
      chk("async reset t_valid_out1", -2, {63'd0, t_valid_out1}, 64'd0);
      inp1 = $realtobits(7.0);
      op = 2'b01;
      t_valid_inp1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("held reset t_valid_out1", -2, {63'd0, t_valid_out1}, 64'd0);
      #1;
      rst = 1'b1;
      push_zeros();
      stepm($realtobits(7.0), 2'b01, 1'b1);
      stepm($realtobits(8.0), 2'b01, 1'b1);
      idle(4);

      // randomized samples
      for (int i = 0; i < 300; i++) begin
         w = {$urandom, $urandom};
         k = $urandom_range(0, 9);
         if (k < 7) w[62:52] = 11'($urandom_range(1000, 1090));
         else if (k == 7) w[62:52] = 11'h7FF;
         else if (k == 8) w[62:52] = 11'h000;
         o = 2'($urandom_range(0, 3));
         v = 1'($urandom_range(0, 1));
         stepm(w, o, v);
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_double2int.md
PE_DOUBLE2INT -- requirements
Module: pe_double2int

Interface
REQ-001 The block SHALL have parameter latency, default 4, fixed pipeline depth in cycles; only the value 4 is supported.
REQ-002 The block SHALL have parameter dwidth_double, default 64, data width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port inp1, input, dwidth_double bits, IEEE-754 double operand or raw bypass word.
REQ-006 The block SHALL have port t_valid_inp1, input, 1 bit, inp1 qualifier.
REQ-007 The block SHALL have port op, input, 2 bits, mode: op[0]=1 convert double to signed int64, op[0]=0 bypass; op[1] reserved and ignored.
REQ-008 The block SHALL have port out1, output, dwidth_double bits, signed int64 result or delayed bypass word.
REQ-009 The block SHALL have port t_valid_out1, output, 1 bit, out1 qualifier.
REQ-010 The block SHALL have port out_ovf, output, 1 bit, per-sample flag: input was NaN, infinity or out of int64 range (convert mode only).

Function
REQ-011 The block SHALL be a 4-stage pipeline in which op[0] and t_valid_inp1 are captured with inp1 each cycle, so mode is selected per sample.
REQ-012 The block SHALL produce each sample's out1, out_ovf and t_valid_out1 exactly 4 cycles after capture, in both modes, with no backpressure.
REQ-013 The block SHALL accept a new sample every cycle; back-to-back samples with alternating op SHALL NOT interfere.
REQ-014 In bypass mode the block SHALL deliver out1 equal to inp1 bit-exact and out_ovf = 0.
REQ-015 In stage 1 the block SHALL unpack sign, 11-bit exponent and 52-bit fraction, and classify the operand as zero/denormal, normal, infinity or NaN.
REQ-016 In stage 2 the block SHALL compute the unbiased exponent e = exp-1023 and the shift amount for the 53-bit significand (hidden 1 restored).
REQ-017 In stage 3 the block SHALL barrel-shift the significand into a 64-bit magnitude: left by e-52 if e>=52, else right by 52-e, discarding shifted-out bits.
REQ-018 In stage 4 the block SHALL apply sign (two's complement negate when sign=1) and saturation, and register the outputs.
REQ-019 Rounding SHALL be toward zero (truncation).
REQ-020 If e<0, or the input is zero or denormal, the result SHALL be 0 with out_ovf=0, including for -0.0.
REQ-021 If the input is positive and e>=63, or is +infinity, the result SHALL be 0x7FFFFFFFFFFFFFFF with out_ovf=1.
REQ-022 If the input is negative and e>63, or is -infinity, the result SHALL be 0x8000000000000000 with out_ovf=1.
REQ-023 If the input is negative with e=63, the result SHALL be 0x8000000000000000; out_ovf SHALL be 0 only when the input is exactly -2^63, else 1.
REQ-024 For any NaN (quiet or signalling, either sign) the result SHALL be 0x8000000000000000 with out_ovf=1.
REQ-025 When a pipeline slot is not valid, its data SHALL still propagate, but downstream consumers SHALL qualify it only by t_valid_out1.

Reset
REQ-026 When rst=0, all pipeline registers SHALL clear asynchronously: out1=0, out_ovf=0, t_valid_out1=0.
REQ-027 Samples in flight at reset assertion SHALL be discarded; none SHALL emerge after deassertion.
REQ-028 The first valid output after deassertion SHALL appear 4 cycles after the first sample captured with rst=1.

Verification
REQ-029 The bench SHALL check convert, op=1: 3.7 (0x400D99999999999A) -> out1=3, ovf=0, valid 4 cycles later; -3.7 -> 0xFFFFFFFFFFFFFFFD.
REQ-030 The bench SHALL check range limits: 2^63 (0x43E0000000000000) -> 0x7FFFFFFFFFFFFFFF, ovf=1; -2^63 (0xC3E0000000000000) -> 0x8000000000000000, ovf=0; +inf (0x7FF0000000000000) -> 0x7FFF..., ovf=1.
REQ-031 The bench SHALL check specials: NaN 0x7FF8000000000000 -> 0x8000000000000000, ovf=1; 0.5 (0x3FE0000000000000) -> 0; denormal 0x0000000000000001 -> 0.
REQ-032 The bench SHALL check bypass: op=0, inp1=0x0123456789ABCDEF -> same word, ovf=0, after exactly 4 cycles.
REQ-033 The bench SHALL run a back-to-back stream of 8 samples alternating op=1 (1.0, 2.0, ...) and op=0 (raw words) -> outputs in order, each matching its own mode, valid high for 8 consecutive cycles.
REQ-034 The bench SHALL pull rst low after 2 of 4 streamed samples are accepted -> outputs 0 immediately, no stale valid after release, next sample emerges 4 cycles after capture.
